// File: rtl/pwm_dac.sv
// PWM DAC: turns a stream of unsigned duty samples into a fixed-period PWM bit.
// Each period is 2^WIDTH-1 clocks. A one-deep pending buffer feeds the active duty at period boundaries.
module pwm_dac #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_sample,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr_underrun,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun,
    output logic             busy
);

    // Last count value of a period: 2^WIDTH-2
    localparam logic [WIDTH-1:0] CNT_LAST = ~WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_wrap;
    logic [WIDTH-1:0] duty_active;
    logic [WIDTH-1:0] pending;
    logic             pending_full;
    logic             boundary;
    logic             first_boundary;
    logic             accept;
    logic             transfer;
    logic             set_underrun;

    // Ready comes straight from the buffer flag, never from in_valid
    assign in_ready = ~pending_full;

    assign cnt_wrap = (cnt_q == CNT_LAST) ? '0 : cnt_q + WIDTH'(1);

    // Next state, next count and period-boundary detection
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        boundary       = 1'b0;
        first_boundary = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d        = RUN;
                    boundary       = 1'b1;
                    first_boundary = 1'b1;
                end
            end
            RUN: begin
                cnt_d    = cnt_wrap;
                boundary = (cnt_q == CNT_LAST);
                if (!enable) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_wrap;
                if (enable) begin
                    state_d  = RUN;
                    boundary = (cnt_q == CNT_LAST);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Accept needs an empty buffer, transfer a full one, so both never fire together
    assign accept       = in_valid & ~pending_full;
    assign transfer     = boundary & pending_full;
    assign set_underrun = boundary & ~pending_full & ~first_boundary;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            duty_active  <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (transfer) begin
                duty_active  <= pending;
                pending_full <= 1'b0;
            end else if (accept) begin
                pending_full <= 1'b1;
            end
            if (accept) begin
                pending <= in_sample;
            end
            if (set_underrun) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
            pwm_out      <= (state_q != IDLE) && (cnt_q < duty_active);
            period_start <= (state_d != IDLE) && (cnt_d == '0);
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Randomized and scenario bench for pwm_dac against a period-level reference model.
module tb_pwm_dac;

    localparam int unsigned WIDTH  = 8;
    localparam int          PERIOD = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] in_sample;
    logic             in_valid;
    logic             in_ready;
    logic             clr_underrun;
    logic             pwm_out;
    logic             period_start;
    logic             underrun;
    logic             busy;

    pwm_dac #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clr_underrun (clr_underrun),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: running flag, position within period, stop request, one-deep sample queue
    bit m_on, m_stopping, m_under, m_pwm, m_ps, m_busy;
    int m_pos, m_duty;
    int m_pend[$];

    task automatic model_reset();
        m_on = 0; m_stopping = 0; m_under = 0; m_pwm = 0; m_ps = 0; m_busy = 0;
        m_pos = 0; m_duty = 0;
        m_pend.delete();
    endtask

    task automatic model_step();
        bit en, on0, full0, took, new_per, first, set_u;
        int pos0, smp;
        en = enable; on0 = m_on; pos0 = m_pos;
        full0 = (m_pend.size() > 0);
        took = in_valid && !full0;
        smp = int'(in_sample);
        new_per = 0; first = 0; set_u = 0;
        m_pwm = on0 && (pos0 < m_duty);
        if (!on0) begin
            if (en) begin
                m_on = 1; m_pos = 0; m_stopping = 0; new_per = 1; first = 1;
            end
        end else if (pos0 == PERIOD - 1) begin
            if (m_stopping && !en) begin
                m_on = 0; m_pos = 0;
            end else begin
                m_pos = 0; new_per = 1; m_stopping = !en;
            end
        end else begin
            m_pos++;
            m_stopping = !en;
        end
        if (new_per) begin
            if (full0) m_duty = m_pend.pop_front();
            else if (!first) set_u = 1;
        end
        if (took) m_pend.push_back(smp);
        if (set_u) m_under = 1;
        else if (clr_underrun) m_under = 0;
        m_ps = m_on && (m_pos == 0);
        m_busy = m_on;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("period_start", 32'(period_start), 32'(m_ps));
        check("busy", 32'(busy), 32'(m_busy));
        check("in_ready", 32'(in_ready), 32'(m_pend.size() == 0));
        check("underrun", 32'(underrun), 32'(m_under));
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; in_valid = 1'b0; in_sample = '0; clr_underrun = 1'b0;
        model_reset();
        #3;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic preload(input int v);
        in_valid = 1'b1;
        in_sample = WIDTH'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        while (period_start !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check("wait_period_start", 32'(period_start), 32'd1);
    endtask

    // Counts high cycles over one full period that began at the last period_start sample
    task automatic one_period(output int hi);
        hi = 0;
        for (int i = 1; i <= PERIOD; i++) begin
            tick();
            hi += int'(pwm_out);
        end
    endtask

    initial begin
        int duties[5];
        int hi, lo;
        int exp_q[$];
        bit accepted;
        duties = '{0, 1, 128, 254, 255};

        // Idle after reset
        do_reset();
        for (int i = 0; i < 600; i++) tick();
        check("idle_pwm", 32'(pwm_out), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_underrun", 32'(underrun), 32'd0);

        // Duty sweep
        foreach (duties[d]) begin
            do_reset();
            preload(duties[d]);
            enable = 1'b1;
            wait_ps();
            for (int p = 0; p < 3; p++) begin
                one_period(hi);
                check($sformatf("sweep_hi_d%0d_p%0d", duties[d], p), 32'(hi), 32'(duties[d]));
                check("sweep_period_start", 32'(period_start), 32'd1);
            end
        end

        // Back-to-back stream, one new sample per period
        do_reset();
        preload(77);
        exp_q.push_back(77);
        enable = 1'b1;
        wait_ps();
        for (int p = 0; p < 5; p++) begin
            hi = 0; lo = 0; accepted = 0;
            for (int i = 1; i <= PERIOD; i++) begin
                if (!accepted && in_ready) begin
                    in_valid = 1'b1;
                    in_sample = WIDTH'($urandom_range(0, 255));
                    exp_q.push_back(int'(in_sample));
                    accepted = 1;
                end
                tick();
                in_valid = 1'b0;
                hi += int'(pwm_out);
                if (!in_ready) lo++;
            end
            check("stream_hi", 32'(hi), 32'(exp_q.pop_front()));
            check("stream_ready_low", 32'(lo >= 1 && lo <= 255), 32'd1);
        end

        // Underrun: duty held, flag sticky until cleared
        do_reset();
        preload(100);
        enable = 1'b1;
        wait_ps();
        check("under_first", 32'(underrun), 32'd0);
        one_period(hi);
        check("under_hi_p0", 32'(hi), 32'd100);
        one_period(hi);
        check("under_hi_p1", 32'(hi), 32'd100);
        check("under_set", 32'(underrun), 32'd1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("under_clear", 32'(underrun), 32'd0);

        // Stop mid-period finishes the period then idles
        do_reset();
        preload(200);
        enable = 1'b1;
        wait_ps();
        hi = 0;
        for (int i = 1; i <= PERIOD; i++) begin
            if (i == 51) enable = 1'b0;
            tick();
            hi += int'(pwm_out);
        end
        check("stop_hi", 32'(hi), 32'd200);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_pwm", 32'(pwm_out), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("stop_pwm_later", 32'(pwm_out), 32'd0);

        // Reset mid-operation takes effect without a clock edge
        do_reset();
        preload(200);
        enable = 1'b1;
        wait_ps();
        preload(50);
        for (int i = 2; i <= 30; i++) tick();
        check("pre_rst_pwm", 32'(pwm_out), 32'd1);
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_pwm", 32'(pwm_out), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_underrun", 32'(underrun), 32'd0);
        for (int i = 0; i < 300; i++) tick();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            in_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: in_sample = '0;
                1: in_sample = '1;
                default: in_sample = WIDTH'($urandom_range(0, 255));
            endcase
            clr_underrun = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the sample width in bits; the PWM period is 2^WIDTH-1 clocks.
REQ-002 The module SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The module SHALL have input enable, 1 bit: 1 = run the modulator, 0 = stop at the end of the current period.
REQ-005 The module SHALL have input in_sample, WIDTH bits: unsigned duty sample from the upstream wave generator/amplitude stage.
REQ-006 The module SHALL have input in_valid, 1 bit: in_sample is valid this cycle.
REQ-007 The module SHALL have output in_ready, 1 bit: pending buffer empty; a sample is accepted on the rising edge when in_valid=1 and in_ready=1.
REQ-008 The module SHALL have input clr_underrun, 1 bit: synchronous clear of the underrun flag.
REQ-009 The module SHALL have output pwm_out, 1 bit: registered PWM bit (the system OUTPUT signal).
REQ-010 The module SHALL have output period_start, 1 bit: one-cycle pulse in the first cycle of each period.
REQ-011 The module SHALL have output underrun, 1 bit: sticky flag for a period boundary with no pending sample.
REQ-012 The module SHALL have output busy, 1 bit: 1 when the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and STOP.
- IDLE->RUN when enable=1.
- RUN->STOP when enable=0.
- STOP->RUN if enable returns to 1 before the period ends.
- STOP->IDLE at the period end (cnt=2^WIDTH-2).
REQ-014 Counter cnt (WIDTH bits) SHALL count 0..2^WIDTH-2 and then wrap to 0 in RUN/STOP; in IDLE it SHALL be held at 0.
REQ-015 period_start SHALL be 1 exactly in the cycles where the FSM is in RUN/STOP and cnt=0.
REQ-016 pwm_out SHALL be registered: pwm_out(t+1) = (state!=IDLE) AND (cnt(t) < duty_active(t)).
- Duty 0 gives constant 0.
- Duty 2^WIDTH-1 gives constant 1.
- Duty D gives exactly D high cycles per period, starting the cycle after period_start.
REQ-017 Duty handling SHALL use one pending register plus a pending_full bit; in_ready = NOT pending_full.
REQ-018 duty_active SHALL be updated only at a period boundary: on the edge into cnt=0, including the IDLE->RUN edge.
- If pending_full=1: duty_active <= pending and pending_full <= 0.
- If pending_full=0: duty_active is unchanged and underrun <= 1.
REQ-019 On the IDLE->RUN transition with pending_full=0, underrun SHALL NOT be set and duty_active SHALL stay unchanged.
REQ-020 There SHALL be no bypass: a sample accepted on the same edge as a boundary with pending_full=0 goes into pending; that boundary still flags underrun.
REQ-021 in_ready SHALL depend only on registered state, and a pending transfer and a new accept SHALL never occur on the same edge.
REQ-022 When underrun is set and clr_underrun=1 on the same edge, set SHALL win.
REQ-023 Samples SHALL be accepted in any state, including IDLE.
REQ-024 in_sample SHALL be ignored when in_valid=0.

Reset
REQ-025 While rst=0, regardless of clk, the module SHALL hold state=IDLE, cnt=0, duty_active=0, pending=0, pending_full=0, pwm_out=0, period_start=0, underrun=0 and busy=0, with in_ready=1.
REQ-026 Reset asserted mid-period SHALL take effect immediately: any pending sample is discarded and pwm_out drops to 0 asynchronously.
REQ-027 After rst deasserts, the first active edge SHALL behave as from IDLE.

Verification
REQ-028 Reset then idle: enable=0 for 600 clocks -> pwm_out=0, busy=0, in_ready=1, underrun=0.
REQ-029 Duty sweep: for each of 0, 1, 128, 254, 255, preload the sample, run 3 periods -> per 255-cycle period, high count = 0/1/128/254/255 respectively, with period_start every 255 clocks.
REQ-030 Back-to-back stream: present a new sample each period while in_ready=1 -> duty changes only at period_start, and in_ready drops for 1..255 cycles after each accept.
REQ-031 Underrun: load 100, run 2 periods without a new sample -> second period also 100 high, underrun=1; pulse clr_underrun -> underrun=0.
REQ-032 Stop mid-period: duty 200, drop enable at cnt=50 -> period completes (200 high cycles), then busy=0 and pwm_out=0.
REQ-033 Reset mid-operation: assert rst at cnt=30 -> pwm_out=0 immediately; after release, in_ready=1 and underrun=0.
